// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/addsub_row.sv
// Ripple add/subtract of one partial-product row: sum = acc + pp, or acc - pp when sub_i is set.
module addsub_row #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] acc_i,
    input  logic [Width-1:0] pp_i,
    input  logic             sub_i,
    output logic [Width-1:0] sum_o
);

    logic [Width-1:0] b_inv;
    logic [Width-1:0] carry;

    assign b_inv    = pp_i ^ {Width{sub_i}};
    assign carry[0] = sub_i;

    for (genvar i = 0; i < Width - 1; i++) begin : g_fa
        full_adder u_fa (
            .a_i  (acc_i[i]),
            .b_i  (b_inv[i]),
            .ci_i (carry[i]),
            .s_o  (sum_o[i]),
            .co_o (carry[i+1])
        );
    end

    // Arithmetic is modulo 2^Width, so the top bit needs no carry-out.
    assign sum_o[Width-1] = acc_i[Width-1] ^ b_inv[Width-1] ^ carry[Width-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one partial-product row per enabled cycle,
// unsigned or two's-complement, with valid/ready handshakes on both sides.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ena_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = cnt_width(WIDTH);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            mode_q, mode_d;

    logic [PW-1:0] a_ext, pp, row_sum;
    logic          last_step, sub;

    assign last_step = (cnt_q == CntW'(WIDTH - 1));
    // The multiplier sign bit carries weight -2^(WIDTH-1) in signed mode.
    assign sub       = (mode_q == MODE_SIGNED) && last_step;
    assign a_ext     = (mode_q == MODE_SIGNED) ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                                               : {{WIDTH{1'b0}}, a_q};
    assign pp        = a_ext << cnt_q;

    addsub_row #(
        .Width (PW)
    ) u_row (
        .acc_i (acc_q),
        .pp_i  (pp),
        .sub_i (sub),
        .sum_o (row_sum)
    );

    assign in_ready_o  = (state_q == StIdle) && ena_i;
    assign out_valid_o = (state_q == StDone);
    assign p_o         = p_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        if (ena_i) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_d     = a_i;
                        b_d     = b_i;
                        mode_d  = signed_mode_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (b_q[cnt_q]) begin
                        acc_d = row_sum;
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (last_step) begin
                        p_d     = acc_d;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_UNSIGNED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ena4, ena8;
    logic       iv4, ir4, sm4, ov4, or4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       iv8, ir8, sm8, ov8, or8;
    logic [7:0] a8, b8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .ena_i         (ena4),
        .in_valid_i    (iv4),
        .in_ready_o    (ir4),
        .signed_mode_i (sm4),
        .a_i           (a4),
        .b_i           (b4),
        .out_valid_o   (ov4),
        .out_ready_i   (or4),
        .p_o           (p4)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk_i         (clk),
        .rst_i         (rst),
        .ena_i         (ena8),
        .in_valid_i    (iv8),
        .in_ready_o    (ir8),
        .signed_mode_i (sm8),
        .a_i           (a8),
        .b_i           (b8),
        .out_valid_o   (ov8),
        .out_ready_i   (or8),
        .p_o           (p8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        while (ov4 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done8(output int cyc, output int rdy_seen);
        cyc      = 0;
        rdy_seen = 0;
        while (ov8 !== 1'b1 && cyc < 40) begin
            if (ir8 === 1'b1) rdy_seen++;
            tick();
            cyc++;
        end
    endtask

    task automatic mul4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic s, input logic [7:0] exp);
        int cyc;
        a4 = a; b4 = b; sm4 = s; iv4 = 1'b1;
        check_eq({tag, "_in_ready"}, 32'(ir4), 32'd1);
        tick();
        iv4 = 1'b0; a4 = '0; b4 = '0;
        wait_done4(cyc);
        check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
        check_eq({tag, "_p"}, 32'(p4), 32'(exp));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, rdy, bad;
        int steps [4] = '{15, 45, 105, 225};

        rst = 1'b1; ena4 = 1'b1; ena8 = 1'b1;
        iv4 = 1'b0; sm4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0;
        iv8 = 1'b0; sm8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_out_valid", 32'(ov4), 32'd0);
        check_eq("rst_in_ready", 32'(ir4), 32'd1);
        check_eq("rst_p", 32'(p4), 32'd0);
        check_eq("rst_acc", 32'(dut4.acc_q), 32'd0);
        check_eq("rst_cnt", 32'(dut4.cnt_q), 32'd0);

        // 15*15 unsigned with per-step accumulator trace
        a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("uu15_in_ready_run", 32'(ir4), 32'd0);
            check_eq("uu15_out_valid_run", 32'(ov4), 32'd0);
            tick();
            check_eq("uu15_acc_step", 32'(dut4.acc_q), 32'(steps[i]));
        end
        check_eq("uu15_out_valid", 32'(ov4), 32'd1);
        check_eq("uu15_p", 32'(p4), 32'h0E1);
        tick();

        mul4("ss_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
        mul4("ss_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
        mul4("uu_zero_b", 4'h9, 4'h0, 1'b0, 8'h00);

        // Backpressure in DONE with a pending operand held on the input side
        or4 = 1'b0;
        a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; iv4 = 1'b1;
        tick();
        a4 = 4'd2; b4 = 4'd3;
        wait_done4(cyc);
        check_eq("bp_latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_out_valid_hold", 32'(ov4), 32'd1);
            check_eq("bp_p_hold", 32'(p4), 32'h0E1);
            check_eq("bp_in_ready_low", 32'(ir4), 32'd0);
        end
        or4 = 1'b1;
        tick();
        check_eq("bp_after_xfer_out_valid", 32'(ov4), 32'd0);
        check_eq("bp_after_xfer_in_ready", 32'(ir4), 32'd1);
        tick();
        iv4 = 1'b0;
        wait_done4(cyc);
        check_eq("bp_next_latency", 32'(cyc), 32'd4);
        check_eq("bp_next_p", 32'(p4), 32'd6);
        tick();

        // Reset mid-RUN of 7*9
        a4 = 4'd7; b4 = 4'd9; sm4 = 1'b0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_run_out_valid", 32'(ov4), 32'd0);
        check_eq("rst_run_in_ready", 32'(ir4), 32'd1);
        check_eq("rst_run_p", 32'(p4), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov4 !== 1'b0) bad++;
        end
        check_eq("rst_run_no_valid", 32'(bad), 32'd0);

        // ena low for two cycles mid-RUN of 7*9
        a4 = 4'd7; b4 = 4'd9; sm4 = 1'b0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        ena4 = 1'b0;
        tick();
        tick();
        check_eq("ena_acc_frozen", 32'(dut4.acc_q), 32'd7);
        check_eq("ena_cnt_frozen", 32'(dut4.cnt_q), 32'd1);
        ena4 = 1'b1;
        wait_done4(cyc);
        check_eq("ena_latency", 32'(cyc + 3), 32'd6);
        check_eq("ena_p", 32'(p4), 32'h3F);
        tick();

        // WIDTH=8: max unsigned, then back-to-back zero product
        a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; iv8 = 1'b1;
        check_eq("w8_in_ready", 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        wait_done8(cyc, rdy);
        check_eq("w8_ff_latency", 32'(cyc), 32'd8);
        check_eq("w8_ff_in_ready_run", 32'(rdy), 32'd0);
        check_eq("w8_ff_p", 32'(p8), 32'hFE01);
        tick();
        a8 = 8'h00; b8 = 8'h80; iv8 = 1'b1;
        check_eq("w8_b2b_in_ready", 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        wait_done8(cyc, rdy);
        check_eq("w8_zero_latency", 32'(cyc), 32'd8);
        check_eq("w8_zero_in_ready_run", 32'(rdy), 32'd0);
        check_eq("w8_zero_p", 32'(p8), 32'h0000);
        tick();
        check_eq("w8_idle_out_valid", 32'(ov8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Parametrised sequential multiplier, successor to the fixed 4x4 combinational array multiplier. It computes WIDTH x WIDTH products in unsigned or two's-complement signed mode, one partial-product row per clock, behind valid/ready handshakes on both sides. It sits between an operand source and a result consumer in the tt_um datapath and trades the array's area for WIDTH cycles of latency.

## Interface
Parameters:
- WIDTH, default 4, operand width; legal range 2..32.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; when low, all registers hold and no handshake transfers occur.
- in_valid  in  1  operands a, b and signed_mode are valid.
- in_ready  out  1  block can accept operands. Equals (state==IDLE) && ena.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer accepts p.
- p  out  2*WIDTH  product, registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 when ena=1.
  - When in_valid && in_ready, capture a_r, b_r and mode_r, clear acc (2*WIDTH) and cnt, then go to RUN.
- RUN: one step per enabled cycle.
  - pp = a_r extended to 2*WIDTH, shifted left by cnt. Extension is sign-extension if mode_r=1, zero-extension otherwise.
  - If b_r[cnt]=1, acc += pp. The exception is mode_r=1 && cnt==WIDTH-1, where acc -= pp (weight of the multiplier sign bit).
  - cnt increments. After the step with cnt==WIDTH-1, load p <= final acc and go to DONE.
- DONE:
  - out_valid=1 and p is stable.
  - On out_ready && ena, go to IDLE. out_valid drops the following cycle.
- Width rules:
  - acc arithmetic is modulo 2^(2*WIDTH).
  - Unsigned: max (2^W-1)^2 fits.
  - Signed: full range fits, including (-2^(W-1))^2 = 2^(2W-2).
- p holds its last product through IDLE and RUN until the next DONE load. p is meaningful only while out_valid=1.
- Boundary conditions:
  - No new operands are accepted while in RUN or DONE; in_ready=0 in both.
  - in_valid held high during DONE is ignored until the block returns to IDLE.
  - rst mid-RUN or mid-DONE aborts the product. No out_valid is produced for it, and the block returns to IDLE.
  - ena low in any state freezes state, cnt, acc and p. out_valid stays asserted if in DONE, but no transfer occurs.
  - b=0 or a=0 still takes the full WIDTH RUN cycles; there is no early termination.

## Timing
- Reset values after rst: state=IDLE, cnt=0, acc=0, p=0, out_valid=0, in_ready=1 (given ena=1).
- Latency, assuming ena held high throughout:
  - Operands are accepted at rising edge E.
  - out_valid=1 from edge E+WIDTH onward, with p valid in the same cycle.
- Throughput: one product per WIDTH+2 cycles when out_ready is held high (accept, WIDTH steps, DONE, IDLE).
- Every cycle with ena=0 adds exactly one cycle of latency.
- in_ready and out_valid are decoded combinationally from the state register and ena. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package mult_pkg holds:
  - the state_t enum (IDLE, RUN, DONE);
  - the MODE_UNSIGNED=0 and MODE_SIGNED=1 constants;
  - a function returning the counter width $clog2(WIDTH).
- One sub-module, addsub_row: a 2*WIDTH-bit ripple add/subtract built from the existing full-adder cell.
  - Inputs: acc, pp, sub.
  - Subtraction is implemented as invert pp plus carry-in = sub.
  - Instantiated once; the FSM, counter and registers live in the top module.

## Test plan
- WIDTH=4, unsigned, a=15, b=15 → out_valid at edge E+4, p=0xE1 (225); acc steps are 15, 45, 105, 225.
- WIDTH=4, signed:
  - a=-8 (0x8), b=-8 (0x8) → p=0x40 (64).
  - a=-3 (0xD), b=5 (0x5) → p=0xF1 (-15).
- WIDTH=8, unsigned:
  - a=0xFF, b=0xFF → p=0xFE01 at edge E+8.
  - back-to-back: a=0, b=0x80 → p=0x0000, with in_ready low during RUN.
- Backpressure, WIDTH=4: 15*15 with out_ready=0 for 3 cycles in DONE → p stays 0xE1, out_valid stays 1, in_ready stays 0. The next operand is accepted only after the transfer completes and the block is back in IDLE.
- Reset and enable:
  - rst pulsed at edge E+2 of a 7*9 product → no out_valid, in_ready=1 on the next cycle, p=0.
  - ena=0 for 2 cycles mid-RUN of 7*9 → p=0x3F (63) at edge E+6.
